// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write/read arbiters.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int STALL_CNT_W = 16;
  localparam int MAX_REQ     = 16;

  // First set bit of valid at or after ptr, wrapping modulo n; 0 when none is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int   idx;
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx[3:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Combinational rotating-priority search; shared with the read-side scheduler.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_any
);

  logic [MAX_REQ-1:0] valid_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    win_id                   = ID_W'(rr_pick(valid_ext, int'(ptr), NUM_REQ));
    win_any                  = |valid;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// Define FIFO_PKT_LOCK_EN to hold each grant until the last word of a packet.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          grant_active,
  output logic [STALL_CNT_W-1:0]        stall_cnt
);

`ifdef FIFO_PKT_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
`else
  localparam bit PKT_LOCK = 1'b0;
`endif

  arb_state_t            state_q, state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt, grant_id_nxt, gid_inc;
  logic [ID_WIDTH-1:0]   pick_ptr, pick_id;
  logic [NUM_REQ-1:0]    holder_mask, pick_valid;
  logic                  pick_any, hold_valid, rotate;
  logic [DATA_WIDTH-1:0] hold_data, last_wr_data;

  assign gid_inc     = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
  assign holder_mask = NUM_REQ'(1) << grant_id;
  assign hold_valid  = req_valid[grant_id];
  assign hold_data   = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  // Without packet lock every beat is a packet boundary.
  assign rotate      = PKT_LOCK ? req_last[grant_id] : 1'b1;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid   (pick_valid),
    .ptr     (pick_ptr),
    .win_id  (pick_id),
    .win_any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      grant_id <= grant_id_nxt;
      rr_ptr   <= rr_ptr_nxt;
      if (state_q == GRANT && fifo_full && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr_en) last_wr_data <= hold_data;
  end

  // In GRANT the holder is excluded and the search starts just past it,
  // so the successor is known in the same cycle as the current beat.
  always_comb begin
    state_nxt    = state_q;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    pick_valid   = req_valid;
    pick_ptr     = rr_ptr;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = GRANT;
          grant_id_nxt = pick_id;
        end
      end
      GRANT: begin
        pick_valid = req_valid & ~holder_mask;
        pick_ptr   = gid_inc;
        if (!fifo_full) begin
          if (hold_valid) begin
            if (rotate) begin
              rr_ptr_nxt = gid_inc;
              if (pick_any) grant_id_nxt = pick_id;
              else          state_nxt    = IDLE;
            end
          end else if (!PKT_LOCK) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_active = (state_q == GRANT);
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    if (!rst && grant_active && !fifo_full) begin
      req_ready  = holder_mask;
      fifo_wr_en = hold_valid;
    end
    fifo_wr_data = fifo_wr_en ? hold_data : last_wr_data;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, fifo_wr_en, grant_active;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic [15:0] stall_cnt;
  int          total = 0;
  int          bad   = 0;

  localparam logic [31:0] DATA_DEF = 32'h13121110;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = DATA_DEF;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_last = '0; fifo_full = 1'b0; req_data = DATA_DEF;
    cyc(); cyc(); #2;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b want=0", fifo_wr_en); end
    total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", grant_active); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_gid got=%0d want=0", grant_id); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cnt); end
    cyc(); rst = 1'b0; #2;
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL arb_cycle_wr_en got=%b want=0", fifo_wr_en); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      cyc(); #2;
      total++; if (grant_id !== 2'(k % 4)) begin bad++; $display("FAIL b2b_gid beat=%0d got=%0d want=%0d", k, grant_id, k % 4); end
      total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en beat=%0d got=%b want=1", k, fifo_wr_en); end
      total++; if (fifo_wr_data !== 8'(8'h10 + k % 4)) begin bad++; $display("FAIL b2b_data beat=%0d got=%h want=%h", k, fifo_wr_data, 8'(8'h10 + k % 4)); end
    end
  endtask

  task automatic test_single();
    do_reset();
    req_data[23:16] = 8'hA5; req_valid = 4'b0100; #2;
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL single_idle_wr_en got=%b want=0", fifo_wr_en); end
    cyc(); #2;
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%b want=1", fifo_wr_en); end
    total++; if (fifo_wr_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", fifo_wr_data); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    cyc(); req_valid = '0; req_data = DATA_DEF;
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0010; #2;
    cyc(); fifo_full = 1'b1; #2;
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL full_gid got=%0d want=1", grant_id); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_ready got=%b want=0000", req_ready); end
    repeat (4) begin
      cyc(); #2;
      total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_wr_en got=%b want=0", fifo_wr_en); end
    end
    cyc(); fifo_full = 1'b0; #2;
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL full_stall_cnt got=%0d want=5", stall_cnt); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL full_hold_gid got=%0d want=1", grant_id); end
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL full_resume_wr_en got=%b want=1", fifo_wr_en); end
    total++; if (fifo_wr_data !== 8'h11) begin bad++; $display("FAIL full_resume_data got=%h want=11", fifo_wr_data); end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL full_resume_ready got=%b want=0010", req_ready); end
    cyc(); req_valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 4'b0001; #2;
    cyc(); #2;
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL sim_prime_wr_en got=%b want=1", fifo_wr_en); end
    cyc(); req_valid = 4'b1001; #2;
    total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL sim_idle_active got=%b want=0", grant_active); end
    cyc(); #2;
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL sim_first_gid got=%0d want=3", grant_id); end
    total++; if (fifo_wr_data !== 8'h13) begin bad++; $display("FAIL sim_first_data got=%h want=13", fifo_wr_data); end
    cyc(); #2;
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL sim_second_gid got=%0d want=0", grant_id); end
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL sim_second_wr_en got=%b want=1", fifo_wr_en); end
    cyc(); req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b1111; #2;
    cyc();
    cyc(); fifo_full = 1'b1; #2;
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL mid_gid got=%0d want=1", grant_id); end
    cyc();
    cyc(); rst = 1'b1; fifo_full = 1'b0; #2;
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL mid_stall_pre got=%0d want=2", stall_cnt); end
    total++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_gate got wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
    cyc(); rst = 1'b0; #2;
    total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL mid_active got=%b want=0", grant_active); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_stall got=%0d want=0", stall_cnt); end
    cyc(); #2;
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_restart_gid got=%0d want=0", grant_id); end
    total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL mid_restart_wr_en got=%b want=1", fifo_wr_en); end
    cyc(); req_valid = '0;
  endtask

`ifdef FIFO_PKT_LOCK_EN
  task automatic test_pkt_lock();
    do_reset();
    req_valid = 4'b0010; #2;
    cyc(); req_valid = 4'b0011; #2;
    total++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL lock_w1 got gid=%0d wr_en=%b want 1/1", grant_id, fifo_wr_en); end
    cyc(); req_valid = 4'b0001; #2;
    total++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL lock_drop got gid=%0d wr_en=%b want 1/0", grant_id, fifo_wr_en); end
    cyc(); req_valid = 4'b0011; #2;
    total++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL lock_w2 got gid=%0d wr_en=%b want 1/1", grant_id, fifo_wr_en); end
    cyc(); req_last = 4'b0010; #2;
    total++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL lock_w3 got gid=%0d wr_en=%b want 1/1", grant_id, fifo_wr_en); end
    cyc(); req_last = '0; #2;
    total++; if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL lock_next got gid=%0d wr_en=%b want 0/1", grant_id, fifo_wr_en); end
    cyc(); req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_full_stall();
    test_simultaneous();
    test_reset_mid_burst();
`ifdef FIFO_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single write port of the team's async FIFO between NUM_REQ producers in the write clock domain. Performs round-robin arbitration over valid/ready requesters and gates every transfer on the FIFO full flag. Drives the write-handler increment strobe and the write data to FIFO memory. Optionally holds a grant for a whole packet.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, FIFO word width
ID_WIDTH, $clog2(NUM_REQ), width of the grant index (derived; not overridden)

Ports:
clk  input  1  write-domain clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks the final word of a packet
req_ready  output  NUM_REQ  one-hot accept; a word transfers when req_valid[i] & req_ready[i]
fifo_full  input  1  FIFO full flag, accurate for the current cycle
fifo_wr_en  output  1  write strobe, drives the write handler increment
fifo_wr_data  output  DATA_WIDTH  word written at fifo_wr_en
grant_id  output  ID_WIDTH  index of the current grant holder
grant_active  output  1  a requester holds the grant
stall_cnt  output  16  saturating count of cycles with a grant held and fifo_full=1

Behaviour:
- Interface: one clock; reset is synchronous and active-high. A reset with rst=1 sampled at a clk edge clears all state at that edge.
- Reset values: rr_ptr=0, state=IDLE, grant_id=0, grant_active=0, stall_cnt=0. req_ready and fifo_wr_en are 0 while rst=1.
- Arbitration:
  - Combinational round-robin.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first requester with req_valid=1 wins.
- Transfer, within a single cycle (zero latency):
  - fifo_wr_en = grant_active & req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_data = req_data[grant_id]. When fifo_wr_en=0 it holds the last written word.
  - fifo_wr_data is registered-free: a mux only, no added latency.
- State machine, states IDLE and GRANT:
  - IDLE: grant_active=0 and no transfer. If any req_valid=1, go to GRANT next cycle with grant_id = the winner. This costs 1 arbitration cycle.
  - GRANT, per-beat mode: on a transfer, rr_ptr <= grant_id+1 (wrapping). The next winner is chosen in the same cycle and the state stays in GRANT, so back-to-back beats from different requesters need no bubble. If no other requester is valid, go to IDLE.
  - GRANT, holder drops valid: if req_valid[grant_id]=0 with no transfer, go to IDLE next cycle and leave rr_ptr unchanged.
- fifo_full=1 in GRANT:
  - The grant is held.
  - No rotation happens.
  - stall_cnt increments and saturates at 16'hFFFF.
- Simultaneous requests: the requester nearest rr_ptr (ascending, wrapping) wins. Any requester waits at most NUM_REQ-1 transfers before it is granted.
- Reset mid-packet: state is discarded. The FIFO pointer state belongs to the write handler and is reset independently.

Optional Feature:
FIFO_PKT_LOCK_EN.
- Defined: a grant is held for the whole packet.
  - rr_ptr advances and the grant releases only on a transfer with req_last[grant_id]=1.
  - If the holder drops req_valid mid-packet, the grant stays in GRANT: fifo_wr_en=0 and the grant is kept.
- Undefined: req_last is ignored and the arbiter rotates every beat as described above.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - STALL_CNT_W=16 constant
  - function rr_pick(valid, ptr) returning the winner index
- One sub-module, rr_priority_pick: the combinational rotating priority search, parameterised on NUM_REQ and reused by the read-side scheduler.

Test Plan:
- Reset with req_valid=4'b1111 held -> outputs are 0 while rst=1. First cycle after rst falls: grant_id=0. Writes follow in order 0,1,2,3,0,... with fifo_wr_en=1 every cycle after the first.
- Only requester 2 valid, data 8'hA5 -> one idle cycle, then fifo_wr_en=1 with fifo_wr_data=8'hA5 and req_ready=4'b0100.
- fifo_full=1 for 5 cycles while requester 1 holds the grant -> req_ready=0, fifo_wr_en=0, stall_cnt=5, grant_id stays 1. The transfer resumes the cycle after full drops.
- Requesters 0 and 3 valid, rr_ptr=1 -> 3 wins first, then 0.
- With FIFO_PKT_LOCK_EN: requester 1 sends a 3-word packet while requester 0 is valid -> 3 consecutive writes from 1, then 0 is granted. A valid drop mid-packet keeps grant_id=1.
- rst=1 asserted mid-burst -> the next cycle shows grant_active=0, stall_cnt=0 and rr_ptr=0, so arbitration restarts from requester 0.
